// File: rtl/addsub_rr_arbiter_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | addsub_rr_arbiter_if: request/response bundle for the shared add/sub    |
// | Rev 1.0 - initial release                                                 |
// +-------------------------------------------------------------------------+
interface addsub_rr_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic             req0_ctrl;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic             req1_ctrl;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic             resp_valid;
   logic             resp_ready;
   logic             resp_id;
   logic [WIDTH-1:0] resp_q;
   logic             resp_cfinal;
   logic             busy;

   // Requesters plus the result consumer.
   modport master (
      output req0_valid, req0_ctrl, req0_a, req0_b,
      output req1_valid, req1_ctrl, req1_a, req1_b,
      output resp_ready,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_q, resp_cfinal, busy
   );

   // The arbiter/datapath.
   modport slave (
      input  req0_valid, req0_ctrl, req0_a, req0_b,
      input  req1_valid, req1_ctrl, req1_a, req1_b,
      input  resp_ready,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_q, resp_cfinal, busy
   );
endinterface
`default_nettype wire

// File: rtl/addsub_rr_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | addsub_rr_arbiter: round-robin access to one shared WIDTH-bit add/sub   |
// | Rev 1.0 - initial release                                                 |
// +-------------------------------------------------------------------------+
module addsub_rr_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   addsub_rr_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_last_grant;
   logic             r_grant_id;
   logic             r_ctrl;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_resp_q;
   logic             r_resp_cfinal;
   logic             r_resp_id;

   logic             w_req_any;
   logic             w_grant_id;
   logic             w_accept;
   logic             w_resp_hs;
   logic             w_sel_ctrl;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH:0]   w_sum;

   // On a tie the requester that did not win last time is chosen.
   assign w_req_any  = bus.req0_valid | bus.req1_valid;
   assign w_grant_id = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;

   // Gated by rst so neither ready can fire while reset is held.
   assign w_accept  = (r_state == IDLE) & w_req_any & ~rst;
   assign w_resp_hs = (r_state == RESP) & bus.resp_ready;

   assign w_sel_ctrl = w_grant_id ? bus.req1_ctrl : bus.req0_ctrl;
   assign w_sel_a    = w_grant_id ? bus.req1_a    : bus.req0_a;
   assign w_sel_b    = w_grant_id ? bus.req1_b    : bus.req0_b;

   // Subtract is a + ~b + 1, so carry-out doubles as the no-borrow flag.
   assign w_b_eff = r_ctrl ? ~r_b : r_b;
   assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_ctrl};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            w_state_nxt = RESP;
         end
         RESP: begin
            if (w_resp_hs) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant_id <= 1'b0;
         r_ctrl     <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
      end else if (w_accept) begin
         r_grant_id <= w_grant_id;
         r_ctrl     <= w_sel_ctrl;
         r_a        <= w_sel_a;
         r_b        <= w_sel_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resp_q      <= '0;
         r_resp_cfinal <= 1'b0;
         r_resp_id     <= 1'b0;
      end else if (r_state == EXEC) begin
         r_resp_q      <= w_sum[WIDTH-1:0];
         r_resp_cfinal <= w_sum[WIDTH];
         r_resp_id     <= r_grant_id;
      end
   end

   // Priority only rotates once the result has actually been consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= 1'b1;
      end else if (w_resp_hs) begin
         r_last_grant <= r_resp_id;
      end
   end

   assign bus.req0_ready  = w_accept & ~w_grant_id;
   assign bus.req1_ready  = w_accept &  w_grant_id;
   assign bus.resp_valid  = (r_state == RESP);
   assign bus.resp_q      = r_resp_q;
   assign bus.resp_cfinal = r_resp_cfinal;
   assign bus.resp_id     = r_resp_id;
   assign bus.busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_addsub_rr_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_addsub_rr_arbiter: directed plan cases plus random traffic vs model  |
// | Rev 1.0 - initial release                                                 |
// +-------------------------------------------------------------------------+
module tb_addsub_rr_arbiter;

   localparam int c_width = 4;
   localparam int c_drop  = 0;
   localparam int c_hold  = 1;
   localparam int c_rand  = 2;

   logic clk;
   logic rst;

   logic       v  [0:1];
   logic       cc [0:1];
   logic [3:0] aa [0:1];
   logic [3:0] bb [0:1];
   logic       rr;

   int n_checks;
   int n_errors;
   int cyc;
   int mode;

   // Reference model: operation in flight, its age and expected result.
   bit m_busy;
   int m_cnt;
   int m_last;
   int m_id;
   int m_q;
   int m_c;

   logic       s_r0, s_r1, s_rv, s_id, s_c, s_busy;
   logic [3:0] s_q;
   int         t_acc;
   bit         t_hs;

   int grants[$];
   int resp_ids[$];
   int resp_qs[$];

   addsub_rr_arbiter_if #(.WIDTH(c_width)) bus ();

   assign bus.req0_valid = v[0];
   assign bus.req0_ctrl  = cc[0];
   assign bus.req0_a     = aa[0];
   assign bus.req0_b     = bb[0];
   assign bus.req1_valid = v[1];
   assign bus.req1_ctrl  = cc[1];
   assign bus.req1_a     = aa[1];
   assign bus.req1_b     = bb[1];
   assign bus.resp_ready = rr;

   addsub_rr_arbiter #(.WIDTH(c_width)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Arithmetic from first principles: subtract as a - b offset by 2^W.
   task automatic ref_op(input bit ctrl, input int a, input int b, output int q, output int c);
      int r;
      if (!ctrl) r = a + b;
      else       r = a - b + (1 << c_width);
      q = r % (1 << c_width);
      c = (r >= (1 << c_width)) ? 1 : 0;
   endtask

   task automatic mreset();
      m_busy = 1'b0;
      m_cnt  = 0;
      m_last = 1;
   endtask

   task automatic new_op(input int k);
      v[k]  = 1'b1;
      cc[k] = 1'($urandom_range(0, 1));
      aa[k] = 4'($urandom_range(0, 15));
      bb[k] = 4'($urandom_range(0, 15));
   endtask

   task automatic set_op(input int k, input bit ctrl, input int a, input int b);
      v[k]  = 1'b1;
      cc[k] = ctrl;
      aa[k] = 4'(a);
      bb[k] = 4'(b);
   endtask

   // One clock: check at the falling edge, advance the model at the rising edge.
   task automatic tick();
      bit has;
      int g;
      @(negedge clk);
      cyc++;
      s_r0 = bus.req0_ready;  s_r1 = bus.req1_ready;  s_rv = bus.resp_valid;
      s_id = bus.resp_id;     s_q  = bus.resp_q;      s_c  = bus.resp_cfinal;
      s_busy = bus.busy;
      has = 1'b0;
      g   = 0;
      if (!m_busy) begin
         if (v[0] && v[1]) begin has = 1'b1; g = (m_last == 1) ? 0 : 1; end
         else if (v[0])    begin has = 1'b1; g = 0; end
         else if (v[1])    begin has = 1'b1; g = 1; end
      end
      chk("ready0", 32'(s_r0), 32'(has && g == 0));
      chk("ready1", 32'(s_r1), 32'(has && g == 1));
      chk("busy", 32'(s_busy), 32'(m_busy));
      chk("resp_valid", 32'(s_rv), 32'(m_busy && m_cnt >= 2));
      if (m_busy && m_cnt >= 2) begin
         chk("resp_id", 32'(s_id), m_id);
         chk("resp_q", 32'(s_q), m_q);
         chk("resp_cfinal", 32'(s_c), m_c);
      end
      @(posedge clk);
      t_acc = -1;
      t_hs  = 1'b0;
      if (has) begin
         m_busy = 1'b1;
         m_cnt  = 1;
         m_id   = g;
         ref_op(cc[g], int'(aa[g]), int'(bb[g]), m_q, m_c);
         grants.push_back(g);
         t_acc = g;
      end else if (m_busy) begin
         if (m_cnt >= 2 && rr) begin
            m_busy = 1'b0;
            m_last = m_id;
            t_hs   = 1'b1;
            resp_ids.push_back(int'(s_id));
            resp_qs.push_back(int'(s_q));
         end else if (m_cnt < 2) begin
            m_cnt++;
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         if (t_acc == k) begin
            if (mode == c_drop) v[k] = 1'b0;
            else if (mode == c_rand) begin
               if ($urandom_range(0, 1) == 1) new_op(k);
               else v[k] = 1'b0;
            end
         end else if (mode == c_rand && !v[k] && $urandom_range(0, 2) == 0) begin
            new_op(k);
         end
      end
      if (mode == c_rand) rr = ($urandom_range(0, 3) != 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      v[0] = 1'b0; v[1] = 1'b0; rr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_resp_q", 32'(bus.resp_q), 0);
      chk("rst_resp_cfinal", 32'(bus.resp_cfinal), 0);
      chk("rst_resp_id", 32'(bus.resp_id), 0);
      rst = 1'b0;
      mreset();
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      mode = c_drop;
      rr   = 1'b1;
      for (int i = 0; i < 30 && !done; i++) begin
         if (!m_busy && !v[0] && !v[1]) done = 1'b1;
         else tick();
      end
      if (!done) chk("drain_timeout", 1, 0);
   endtask

   task automatic do_op(input int id, input bit ctrl, input int a, input int b,
                        input int eq, input int ec);
      int  acc_c;
      int  rv_c;
      bit  done;
      acc_c = -1; rv_c = -1; done = 1'b0;
      mode = c_drop;
      rr   = 1'b1;
      set_op(id, ctrl, a, b);
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         if (t_acc == id && acc_c < 0) acc_c = cyc;
         if (s_rv && rv_c < 0) rv_c = cyc;
         if (t_hs) begin
            chk("plan_q", 32'(s_q), eq);
            chk("plan_cfinal", 32'(s_c), ec);
            chk("plan_id", 32'(s_id), id);
            chk("plan_latency", rv_c - acc_c, 2);
            done = 1'b1;
         end
      end
      if (!done) chk("op_timeout", 0, 1);
   endtask

   task automatic reset_mid(input bit in_resp);
      mode = c_drop;
      rr   = 1'b0;
      set_op(0, 1'b0, 6, 1);
      tick();
      if (in_resp) tick();
      set_op(1, 1'b0, 1, 1);
      set_op(0, 1'b0, 2, 2);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_ready0", 32'(bus.req0_ready), 0);
      chk("mid_rst_ready1", 32'(bus.req1_ready), 0);
      @(posedge clk);
      #1;
      chk("hold_rst_ready0", 32'(bus.req0_ready), 0);
      chk("hold_rst_ready1", 32'(bus.req1_ready), 0);
      rst = 1'b0;
      mreset();
      grants.delete();
      tick();
      if (grants.size() > 0) chk("post_rst_first_grant", grants[0], 0);
      else chk("post_rst_no_grant", 0, 1);
      drain();
   endtask

   initial begin
      int hold_q;
      bit seen;
      n_checks = 0; n_errors = 0; cyc = 0; mode = c_drop;
      v[0] = 1'b0; v[1] = 1'b0; cc[0] = 1'b0; cc[1] = 1'b0;
      aa[0] = '0; aa[1] = '0; bb[0] = '0; bb[1] = '0; rr = 1'b0;
      t_acc = -1; t_hs = 1'b0;
      mreset();
      do_reset();

      do_op(0, 1'b0, 4, 7, 4'b1011, 0);
      do_op(1, 1'b0, 5, 15, 4'b0100, 1);
      do_op(0, 1'b1, 8, 7, 4'b0001, 1);
      do_op(1, 1'b1, 15, 5, 4'b1010, 1);
      do_op(0, 1'b1, 4, 7, 4'b1101, 0);

      // Contention from reset: both hold the same operation continuously.
      do_reset();
      grants.delete(); resp_ids.delete(); resp_qs.delete();
      set_op(0, 1'b1, 9, 5);
      set_op(1, 1'b0, 2, 10);
      mode = c_hold;
      rr   = 1'b1;
      repeat (12) tick();
      v[0] = 1'b0; v[1] = 1'b0;
      drain();
      if (grants.size() >= 4 && resp_qs.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("cont_grant", grants[i], i % 2);
            chk("cont_resp_id", resp_ids[i], i % 2);
            chk("cont_resp_q", resp_qs[i], (resp_ids[i] == 1) ? 4'b1100 : 4'b0100);
         end
      end else begin
         chk("cont_count", grants.size(), 4);
      end

      // Backpressure: result parked in RESP while requester 1 waits.
      mode = c_drop;
      rr   = 1'b0;
      set_op(0, 1'b0, 3, 3);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (s_rv) seen = 1'b1;
      end
      if (!seen) chk("bp_timeout", 0, 1);
      hold_q = int'(s_q);
      set_op(1, 1'b1, 1, 2);
      repeat (5) begin
         tick();
         chk("bp_q_stable", 32'(s_q), hold_q);
         chk("bp_busy", 32'(s_busy), 1);
         chk("bp_ready1", 32'(s_r1), 0);
      end
      rr = 1'b1;
      tick();
      chk("bp_handshake", 32'(t_hs), 1);
      tick();
      chk("bp_next_grant", 32'(s_r1), 1);
      drain();

      reset_mid(1'b0);
      reset_mid(1'b1);

      mode = c_rand;
      for (int i = 0; i < 1500; i++) tick();
      v[0] = 1'b0; v[1] = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
